// File: rtl/keypad_cntr.sv
// 4x4 matrix keypad scanner with press/release debounce and a one-cycle key_valid per accepted key.
// Define KEYPAD_REPEAT_EN to emit extra key_valid pulses while a key stays held.
module keypad_cntr #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_CNT   = 50
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_down
);

  localparam int SLOT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT);

  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("keypad_cntr: SCAN_DIV must be at least 4");
  end
  if (DEBOUNCE_CNT < 1) begin : g_bad_debounce
    $error("keypad_cntr: DEBOUNCE_CNT must be at least 1");
  end
  if (REPEAT_CNT < 1) begin : g_bad_repeat
    $error("keypad_cntr: REPEAT_CNT must be at least 1");
  end

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [3:0]        row_meta, row_sync;
  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        col_idx, col_idx_n;
  logic [3:0]        rec_row, rec_row_n;
  logic [DEB_W-1:0]  deb_cnt, deb_cnt_n;
  logic [3:0]        key_value_n;
  logic              key_valid_n, key_down_n;
  logic              sample, one_low, all_high, accept, key_release;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CNT + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT);
  logic [REP_W-1:0] rep_cnt, rep_cnt_n;
`endif

  function automatic logic [1:0] row_index(input logic [3:0] pattern);
    logic [1:0] idx;
    idx = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!pattern[r]) idx = 2'(r);
    end
    return idx;
  endfunction

  // Rows come straight from the keypad switches, so they are synchronized before any use.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p)     slot_cnt <= '0;
    else if (sample) slot_cnt <= '0;
    else             slot_cnt <= slot_cnt + 1'b1;
  end

  assign sample   = (slot_cnt == SLOT_LAST);
  assign one_low  = ($countones(~row_sync) == 1);
  assign all_high = &row_sync;
  assign col      = ~(4'b0001 << col_idx);

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      rec_row   <= 4'hF;
      deb_cnt   <= '0;
      key_value <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      state     <= state_n;
      col_idx   <= col_idx_n;
      rec_row   <= rec_row_n;
      deb_cnt   <= deb_cnt_n;
      key_value <= key_value_n;
      key_valid <= key_valid_n;
      key_down  <= key_down_n;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= rep_cnt_n;
`endif
    end
  end

  // The detecting sample counts as the first match, for both press and release.
  always_comb begin
    state_n     = state;
    col_idx_n   = col_idx;
    rec_row_n   = rec_row;
    deb_cnt_n   = deb_cnt;
    key_value_n = key_value;
    key_valid_n = 1'b0;
    key_down_n  = key_down;
    accept      = 1'b0;
    key_release = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_n   = rep_cnt;
`endif

    if (sample) begin
      unique case (state)
        SCAN: begin
          if (one_low) begin
            rec_row_n = row_sync;
            deb_cnt_n = DEB_W'(1);
            if (deb_cnt_n == DEB_LAST) accept = 1'b1;
            else                       state_n = DEB_PRESS;
          end else begin
            col_idx_n = col_idx + 1'b1;
          end
        end
        DEB_PRESS: begin
          if (row_sync == rec_row) begin
            deb_cnt_n = deb_cnt + 1'b1;
            if (deb_cnt_n == DEB_LAST) accept = 1'b1;
          end else begin
            state_n   = SCAN;
            col_idx_n = col_idx + 1'b1;
          end
        end
        PRESSED: begin
          if (all_high) begin
            deb_cnt_n = DEB_W'(1);
            if (deb_cnt_n == DEB_LAST) key_release = 1'b1;
            else                       state_n = DEB_REL;
          end else begin
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_n = rep_cnt + 1'b1;
            if (rep_cnt_n == REP_LAST) begin
              key_valid_n = 1'b1;
              rep_cnt_n   = '0;
            end
`endif
          end
        end
        DEB_REL: begin
          if (all_high) begin
            deb_cnt_n = deb_cnt + 1'b1;
            if (deb_cnt_n == DEB_LAST) key_release = 1'b1;
          end else begin
            state_n = PRESSED;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_n = '0;
`endif
          end
        end
      endcase
    end

    if (accept) begin
      state_n     = PRESSED;
      key_value_n = {row_index(rec_row_n), col_idx};
      key_valid_n = 1'b1;
      key_down_n  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_n   = '0;
`endif
    end

    if (key_release) begin
      state_n    = SCAN;
      key_down_n = 1'b0;
      col_idx_n  = col_idx + 1'b1;
    end
  end

endmodule
